top_level_0: RTL and testbench

Self-contained fixed-point-to-half-precision converter with its own data memory. On a start pulse it reads a signed Q8.8 two's-complement value from data memory bytes 1:0. It writes the IEEE-754 binary16 equivalent to bytes 3:2, then raises `done`. It is the program-1 top level of the lab processor; the bench loads operands and reads results through the memory instance.

---
 rtl/top_level_0_if.sv | 14 +
 rtl/top_level_0.sv | 187 ++++++++++++++++++
 tb/tb_top_level_0.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/top_level_0_if.sv
`timescale 1ns/1ps
// top_level_0_if
// Handshake bundle between the converter and whoever drives it.
//   start : request; a conversion is launched by its rising edge
//   done  : registered, high while the converter sits in its DONE state
// The master modport belongs to the requester (bench or sequencer) and the
// slave modport belongs to the converter.
interface top_level_0_if;
    logic start;
    logic done;

    modport master (output start, input done);
    modport slave  (input start, output done);
endinterface

// File: rtl/top_level_0.sv
`timescale 1ns/1ps
// top_level_0
// Program-1 top level of the lab processor: converts a signed Q8.8 value held
// in data memory bytes 1:0 into IEEE-754 binary16 and stores it in bytes 3:2.
//
// Ports:
//   clk    : single clock, all state updates on the rising edge
//   reset  : asynchronous, active-high; returns the FSM to IDLE, memory is kept
//   bus    : top_level_0_if.slave (start in, done out)
//
// Parameters:
//   DM_DEPTH : data memory depth in bytes (only addresses 0..3 are touched)
//
// Configuration macro:
//   ROUND_NEAREST_EN : when defined, the mantissa is rounded to nearest,
//                      ties to even; otherwise it is truncated.

// Byte-wide data memory with a 16-bit little-endian write port and a
// combinational 16-bit read port. Contents are deliberately not reset.
module data_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);
    logic [7:0] mem_core [DEPTH];

    // Both bytes of the result land on the same edge so a reset can never
    // leave half a result behind.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_core[waddr]          <= wdata[7:0];
            mem_core[waddr + AW'(1)] <= wdata[15:8];
        end
    end

    assign rdata = {mem_core[raddr + AW'(1)], mem_core[raddr]};
endmodule

module top_level_0 #(
    parameter int DM_DEPTH = 256
) (
    input  logic          clk,
    input  logic          reset,
    top_level_0_if.slave  bus
);
    localparam int AW = $clog2(DM_DEPTH);
    localparam logic [AW-1:0] OPERAND_ADDR = AW'(0);
    localparam logic [AW-1:0] RESULT_ADDR  = AW'(2);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        NORM = 3'd2,
        PACK = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        start_q;
    logic        trigger;
    logic        done_q;
    logic        sign_q;
    logic        zero_q;
    logic [15:0] mag_q;
    logic [3:0]  exp_q;
    logic [15:0] result_q;
    logic [15:0] operand;
    logic [15:0] mag_in;
    logic        mem_we;
    logic [15:0] packed_word;

    data_mem #(.DEPTH(DM_DEPTH)) dm (
        .clk   (clk),
        .we    (mem_we),
        .waddr (RESULT_ADDR),
        .wdata (result_q),
        .raddr (OPERAND_ADDR),
        .rdata (operand)
    );

    // A held start must only launch one conversion, so we act on the
    // low-to-high transition seen across two samples.
    assign trigger = bus.start && !start_q;

    // Two's-complement magnitude; 0x8000 naturally maps to 0x8000, which the
    // 16-bit unsigned magnitude represents exactly.
    assign mag_in = operand[15] ? (~operand + 16'd1) : operand;

    assign mem_we   = (state == WR);
    assign bus.done = done_q;

    // Next-state logic for the conversion sequence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (trigger) next_state = RD;
            RD:         next_state = (mag_in == 16'd0) ? PACK : NORM;
            NORM:       if (mag_q[15]) next_state = PACK;
            PACK:       next_state = WR;
            WR:         next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    // Assemble the half-precision word from the normalised magnitude. exp_q
    // holds the bit position of the original leading one, so the biased
    // exponent is that position plus 15 minus the 8 fraction bits of Q8.8.
    always_comb begin
        logic [4:0] biased_exp;
        biased_exp  = {1'b0, exp_q} + 5'd7;
        packed_word = 16'd0;
`ifdef ROUND_NEAREST_EN
        begin
            logic       guard;
            logic       sticky;
            logic       round_up;
            logic [14:0] body;
            guard    = mag_q[4];
            sticky   = |mag_q[3:0];
            round_up = guard && (sticky || mag_q[5]);
            // A mantissa carry ripples into the exponent and clears the
            // mantissa, which is exactly what adding to the joined field does.
            body        = {biased_exp, mag_q[14:5]} + 15'(round_up);
            packed_word = {sign_q, body};
        end
`else
        packed_word = {sign_q, biased_exp, mag_q[14:5]};
`endif
    end

`ifndef ROUND_NEAREST_EN
    logic unused_low_bits;
    assign unused_low_bits = ^mag_q[4:0];
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath registers and the registered done flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            mag_q    <= 16'd0;
            exp_q    <= 4'd0;
            result_q <= 16'd0;
        end else begin
            start_q <= bus.start;
            done_q  <= (next_state == DONE);
            case (state)
                RD: begin
                    sign_q <= operand[15];
                    zero_q <= (mag_in == 16'd0);
                    mag_q  <= mag_in;
                    exp_q  <= 4'd15;
                end
                NORM: begin
                    if (!mag_q[15]) begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - 4'd1;
                    end
                end
                PACK: begin
                    // Zero never produces a negative zero.
                    result_q <= zero_q ? 16'd0 : packed_word;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_top_level_0.sv
`timescale 1ns/1ps
// tb_top_level_0
// Directed and randomised bench for the Q8.8 to binary16 converter. Operands
// are loaded and results read straight through dut.dm.mem_core.
module tb_top_level_0;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    top_level_0_if bus ();

    top_level_0 #(.DM_DEPTH(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] read_result();
        return {dut.dm.mem_core[3], dut.dm.mem_core[2]};
    endfunction

    // Reference conversion computed from the numeric definition.
    function automatic logic [15:0] model(input logic [15:0] x);
        logic        s;
        logic [15:0] m;
        logic [15:0] n;
        int          p;
        logic [14:0] body;
        s = x[15];
        m = s ? (16'd0 - x) : x;
        if (m == 16'd0) return 16'h0000;
        p = 0;
        for (int i = 0; i < 16; i++) if (m[i]) p = i;
        n = m << (15 - p);
        body = {5'(p + 7), n[14:5]};
`ifdef ROUND_NEAREST_EN
        if (n[4] && ((|n[3:0]) || n[5])) body = body + 15'd1;
`endif
        return {s, body};
    endfunction

    function automatic int model_edge(input logic [15:0] x);
        logic [15:0] m;
        int          p;
        m = x[15] ? (16'd0 - x) : x;
        if (m == 16'd0) return 3;
        p = 0;
        for (int i = 0; i < 16; i++) if (m[i]) p = i;
        return 4 + (15 - p);
    endfunction

    // Loads an operand, raises start for 'hold' sampled edges and reports the
    // edge number (trigger edge = 0) at which done was first seen high.
    // done_edge stays 0 if done never rose within the budget.
    task automatic convert(input logic [15:0] x, input int hold,
                           output int done_edge, output logic done_at_edge0);
        dut.dm.mem_core[0] = x[7:0];
        dut.dm.mem_core[1] = x[15:8];
        bus.start     = 1'b1;
        done_edge     = 0;
        done_at_edge0 = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) done_at_edge0 = bus.done;
            if (k == hold - 1) bus.start = 1'b0;
            if (bus.done && done_edge == 0 && k > 0) done_edge = k;
            if (done_edge != 0 && k >= hold - 1) break;
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < 256; i++) dut.dm.mem_core[i] = 8'h00;
        dut.dm.mem_core[2] = 8'hA5;
        dut.dm.mem_core[3] = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_done: got %b expected 0", bus.done);
        end
        total++;
        if (dut.state !== 3'd0) begin
            bad++;
            $display("[TB] FAIL reset_state: got %0d expected 0", dut.state);
        end
        total++;
        if (read_result() !== 16'h5AA5) begin
            bad++;
            $display("[TB] FAIL reset_mem_kept: got %h expected 5aa5", read_result());
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int   e;
        logic d0;
        convert(16'h0001, 2, e, d0);
        total++;
        if (read_result() !== 16'h1C00) begin
            bad++;
            $display("[TB] FAIL basic_0001_result: got %h expected 1c00", read_result());
        end
        total++;
        if (e !== 19) begin
            bad++;
            $display("[TB] FAIL basic_0001_latency: got %0d expected 19", e);
        end
        convert(16'h0000, 1, e, d0);
        total++;
        if (read_result() !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL basic_zero_result: got %h expected 0000", read_result());
        end
        total++;
        if (e !== 3) begin
            bad++;
            $display("[TB] FAIL basic_zero_latency: got %0d expected 3", e);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] vin  [7];
        logic [15:0] vexp [7];
        int          vedge[7];
        int          e;
        logic        d0;
        vin[0] = 16'h0030; vexp[0] = 16'h3200; vedge[0] = 14;
`ifdef ROUND_NEAREST_EN
        vin[1] = 16'h1FFF; vexp[1] = 16'h5000; vedge[1] = 7;
        vin[2] = 16'h7FFF; vexp[2] = 16'h5800; vedge[2] = 5;
        vin[6] = 16'h8001; vexp[6] = 16'hD800; vedge[6] = 5;
`else
        vin[1] = 16'h1FFF; vexp[1] = 16'h4FFF; vedge[1] = 7;
        vin[2] = 16'h7FFF; vexp[2] = 16'h57FF; vedge[2] = 5;
        vin[6] = 16'h8001; vexp[6] = 16'hD7FF; vedge[6] = 5;
`endif
        vin[3] = 16'hFFFF; vexp[3] = 16'h9C00; vedge[3] = 19;
        vin[4] = 16'hFFD0; vexp[4] = 16'hB200; vedge[4] = 14;
        vin[5] = 16'h8000; vexp[5] = 16'hD800; vedge[5] = 4;
        for (int i = 0; i < 7; i++) begin
            convert(vin[i], 1, e, d0);
            total++;
            if (read_result() !== vexp[i]) begin
                bad++;
                $display("[TB] FAIL vector_%h_result: got %h expected %h", vin[i], read_result(), vexp[i]);
            end
            total++;
            if (e !== vedge[i]) begin
                bad++;
                $display("[TB] FAIL vector_%h_latency: got %0d expected %0d", vin[i], e, vedge[i]);
            end
        end
    endtask

    task automatic test_held_start();
        int   e;
        logic d0;
        convert(16'h0030, 20, e, d0);
        total++;
        if (e !== 14) begin
            bad++;
            $display("[TB] FAIL held_latency: got %0d expected 14", e);
        end
        total++;
        if (read_result() !== 16'h3200) begin
            bad++;
            $display("[TB] FAIL held_result: got %h expected 3200", read_result());
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL held_done_stays: got %b expected 1", bus.done);
        end
        convert(16'hFFD0, 1, e, d0);
        total++;
        if (d0 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL retrigger_done_drop: got %b expected 0", d0);
        end
        total++;
        if (read_result() !== 16'hB200 || e !== 14) begin
            bad++;
            $display("[TB] FAIL retrigger_conv: got %h/%0d expected b200/14", read_result(), e);
        end
    endtask

    task automatic test_reset_mid();
        int   e;
        logic d0;
        dut.dm.mem_core[0] = 8'h01;
        dut.dm.mem_core[1] = 8'h00;
        bus.start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        #3;
        reset = 1'b1;
        #1;
        total++;
        if (bus.done !== 1'b0 || dut.state !== 3'd0) begin
            bad++;
            $display("[TB] FAIL mid_reset_state: got done=%b state=%0d expected done=0 state=0", bus.done, dut.state);
        end
        total++;
        if (read_result() !== 16'hB200) begin
            bad++;
            $display("[TB] FAIL mid_reset_mem: got %h expected b200", read_result());
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        convert(16'h8000, 1, e, d0);
        total++;
        if (read_result() !== 16'hD800 || e !== 4) begin
            bad++;
            $display("[TB] FAIL after_reset_conv: got %h/%0d expected d800/4", read_result(), e);
        end
    endtask

    task automatic test_random();
        logic [15:0] x;
        logic [15:0] exp_r;
        int          exp_e;
        int          e;
        int          corrupt;
        logic        d0;
        for (int i = 4; i < 256; i++) dut.dm.mem_core[i] = 8'(i) ^ 8'h5A;
        for (int n = 0; n < 100; n++) begin
            x = 16'($urandom) >> $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) x = 16'd0 - x;
            exp_r = model(x);
            exp_e = model_edge(x);
            convert(x, 1, e, d0);
            total++;
            if (read_result() !== exp_r || e !== exp_e) begin
                bad++;
                $display("[TB] FAIL random_%h: got %h/%0d expected %h/%0d", x, read_result(), e, exp_r, exp_e);
            end
            total++;
            if ({dut.dm.mem_core[1], dut.dm.mem_core[0]} !== x) begin
                bad++;
                $display("[TB] FAIL random_operand_kept: got %h expected %h",
                         {dut.dm.mem_core[1], dut.dm.mem_core[0]}, x);
            end
        end
        corrupt = 0;
        for (int i = 4; i < 256; i++)
            if (dut.dm.mem_core[i] !== (8'(i) ^ 8'h5A)) corrupt++;
        total++;
        if (corrupt !== 0) begin
            bad++;
            $display("[TB] FAIL upper_mem_untouched: got %0d changed bytes expected 0", corrupt);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_vectors();
        test_held_start();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
